// File: rtl/regbank_pkg.sv
// Shared constants and FSM state type for the register-bank write arbiter.
package regbank_pkg;

    localparam int DW   = 8;
    localparam int NREG = 4;
    localparam int AW   = $clog2(NREG);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; prio names the requester that wins the next tie.
module rr_arb2 (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic a_valid,
    input  logic b_valid,
    output logic a_grant,
    output logic b_grant,
    output logic prio
);

    always_comb begin
        a_grant = en & a_valid & (~b_valid | ~prio);
        b_grant = en & b_valid & (~a_valid |  prio);
    end

    // Only a contested grant moves the pointer, and it always moves to the loser.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prio <= 1'b0;
        end else if (a_grant & b_valid) begin
            prio <= 1'b1;
        end else if (b_grant & a_valid) begin
            prio <= 1'b0;
        end
    end

endmodule

// File: rtl/regbank_arbiter.sv
// Arbitrates two write requesters onto a small register bank and sequences a
// bank-wide clear; the bank itself lives outside and consumes wr_sel/wr_data.
module regbank_arbiter
    import regbank_pkg::*;
#(
    parameter int DW   = regbank_pkg::DW,
    parameter int NREG = regbank_pkg::NREG
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     a_valid,
    input  logic [$clog2(NREG)-1:0]  a_addr,
    input  logic [DW-1:0]            a_data,
    output logic                     a_ready,
    input  logic                     b_valid,
    input  logic [$clog2(NREG)-1:0]  b_addr,
    input  logic [DW-1:0]            b_data,
    output logic                     b_ready,
    input  logic                     clr_req,
    output logic                     clr_busy,
    input  logic [$clog2(NREG)-1:0]  rd_addr,
    output logic [$clog2(NREG)-1:0]  rd_sel,
    output logic                     rd_hazard,
    output logic [NREG-1:0]          wr_sel,
    output logic [DW-1:0]            wr_data,
    output state_t                   state_dbg,
    output logic                     prio_dbg
);

    localparam int AW = $clog2(NREG);

    // Handshake: a transfer happens on a rising edge where valid & ready are both
    // high; ready never depends on the request's own addr/data, and a requester
    // that is not accepted keeps valid/addr/data stable until it is.

    function automatic logic [NREG-1:0] dec(input logic [AW-1:0] idx);
        logic [NREG-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    state_t          state, state_n;
    logic [AW-1:0]   cnt, cnt_n;
    logic [NREG-1:0] wr_sel_n;
    logic [DW-1:0]   wr_data_n;
    logic            arb_en, a_grant, b_grant, prio;

    // Grants are suppressed while in reset, while clearing, and in the cycle a clear starts.
    assign arb_en = reset & (state == ST_IDLE) & ~clr_req;

    rr_arb2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .en      (arb_en),
        .a_valid (a_valid),
        .b_valid (b_valid),
        .a_grant (a_grant),
        .b_grant (b_grant),
        .prio    (prio)
    );

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        wr_sel_n  = '0;
        wr_data_n = wr_data;
        case (state)
            ST_IDLE: begin
                if (clr_req) begin
                    state_n   = ST_CLEAR;
                    cnt_n     = '0;
                    wr_sel_n  = dec('0);
                    wr_data_n = '0;
                end else if (a_grant) begin
                    wr_sel_n  = dec(a_addr);
                    wr_data_n = a_data;
                end else if (b_grant) begin
                    wr_sel_n  = dec(b_addr);
                    wr_data_n = b_data;
                end
            end
            ST_CLEAR: begin
                // wr_sel already shows one-hot(cnt); line up the next clear write.
                if (cnt == AW'(NREG - 1)) begin
                    state_n = ST_IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n    = cnt + AW'(1);
                    wr_sel_n = dec(cnt + AW'(1));
                end
            end
            default: begin
                state_n = ST_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            wr_sel  <= '0;
            wr_data <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            wr_sel  <= wr_sel_n;
            wr_data <= wr_data_n;
        end
    end

    assign a_ready   = a_grant;
    assign b_ready   = b_grant;
    assign clr_busy  = (state == ST_CLEAR);
    assign rd_sel    = rd_addr;
    assign rd_hazard = |(wr_sel & dec(rd_addr));
    assign state_dbg = state;
    assign prio_dbg  = prio;

endmodule

// File: tb/tb_regbank_arbiter.sv
// Bench for regbank_arbiter: directed scenarios plus a randomized run against a
// write-schedule reference model and a bench-side register bank.
module tb_regbank_arbiter;
    import regbank_pkg::*;

    logic            clk = 1'b0;
    logic            reset;
    logic            a_valid, b_valid, clr_req;
    logic [AW-1:0]   a_addr, b_addr, rd_addr;
    logic [DW-1:0]   a_data, b_data;
    logic            a_ready, b_ready, clr_busy, rd_hazard, prio_dbg;
    logic [AW-1:0]   rd_sel;
    logic [NREG-1:0] wr_sel;
    logic [DW-1:0]   wr_data;
    state_t          state_dbg;

    int checks = 0;
    int errors = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    regbank_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .a_valid   (a_valid),
        .a_addr    (a_addr),
        .a_data    (a_data),
        .a_ready   (a_ready),
        .b_valid   (b_valid),
        .b_addr    (b_addr),
        .b_data    (b_data),
        .b_ready   (b_ready),
        .clr_req   (clr_req),
        .clr_busy  (clr_busy),
        .rd_addr   (rd_addr),
        .rd_sel    (rd_sel),
        .rd_hazard (rd_hazard),
        .wr_sel    (wr_sel),
        .wr_data   (wr_data),
        .state_dbg (state_dbg),
        .prio_dbg  (prio_dbg)
    );

    // Bench-side bank driven by the write port, preset to a non-zero pattern.
    logic [DW-1:0] tb_bank [NREG];
    logic          bank_preset;

    always @(posedge clk) begin
        for (int i = 0; i < NREG; i++) begin
            if (bank_preset) tb_bank[i] <= 8'hA5;
            else if (wr_sel[i]) tb_bank[i] <= wr_data;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        a_valid = 1'b0; a_addr = '0; a_data = '0;
        b_valid = 1'b0; b_addr = '0; b_data = '0;
        clr_req = 1'b0; rd_addr = '0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        bank_preset = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        bank_preset = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        @(negedge clk);
        reset = 1'b0;
        bank_preset = 1'b1;
        idle_inputs();
        a_valid = 1'b1; b_valid = 1'b1; b_addr = 2'd1;
        #1;
        checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL reset_a_ready: got %b want 0", a_ready); end
        checks++; if (b_ready !== 1'b0) begin errors++; $display("FAIL reset_b_ready: got %b want 0", b_ready); end
        checks++; if (wr_sel !== 4'b0000) begin errors++; $display("FAIL reset_wr_sel: got %b want 0000", wr_sel); end
        checks++; if (wr_data !== 8'h00) begin errors++; $display("FAIL reset_wr_data: got %h want 00", wr_data); end
        checks++; if (clr_busy !== 1'b0) begin errors++; $display("FAIL reset_clr_busy: got %b want 0", clr_busy); end
        checks++; if (state_dbg !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d want IDLE", state_dbg); end
        checks++; if (prio_dbg !== 1'b0) begin errors++; $display("FAIL reset_prio: got %b want 0", prio_dbg); end
        @(negedge clk);
        idle_inputs();
        reset = 1'b1;
        bank_preset = 1'b0;
        @(negedge clk); #1;
        checks++; if (wr_sel !== 4'b0000) begin errors++; $display("FAIL reset_release_wr_sel: got %b want 0000", wr_sel); end
    endtask

    task automatic test_a_only();
        apply_reset();
        @(negedge clk);
        a_valid = 1'b1; a_addr = 2'd2; a_data = 8'h5A;
        #1;
        checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL a_only_ready: got %b want 1", a_ready); end
        checks++; if (b_ready !== 1'b0) begin errors++; $display("FAIL a_only_b_ready: got %b want 0", b_ready); end
        @(negedge clk);
        a_valid = 1'b0;
        #1;
        checks++; if (wr_sel !== 4'b0100) begin errors++; $display("FAIL a_only_wr_sel: got %b want 0100", wr_sel); end
        checks++; if (wr_data !== 8'h5A) begin errors++; $display("FAIL a_only_wr_data: got %h want 5a", wr_data); end
        @(negedge clk); #1;
        checks++; if (wr_sel !== 4'b0000) begin errors++; $display("FAIL a_only_after_sel: got %b want 0000", wr_sel); end
        checks++; if (wr_data !== 8'h5A) begin errors++; $display("FAIL a_only_hold_data: got %h want 5a", wr_data); end
    endtask

    task automatic test_contention();
        apply_reset();
        @(negedge clk);
        a_valid = 1'b1; a_addr = 2'd0; a_data = 8'h11;
        b_valid = 1'b1; b_addr = 2'd1; b_data = 8'h22;
        #1;
        checks++; if ({a_ready, b_ready} !== 2'b10) begin errors++; $display("FAIL cont_first_grant: got %b want 10", {a_ready, b_ready}); end
        @(negedge clk); #1;
        checks++; if (wr_sel !== 4'b0001) begin errors++; $display("FAIL cont_wr_sel_a: got %b want 0001", wr_sel); end
        checks++; if (wr_data !== 8'h11) begin errors++; $display("FAIL cont_wr_data_a: got %h want 11", wr_data); end
        checks++; if (prio_dbg !== 1'b1) begin errors++; $display("FAIL cont_prio_after_a: got %b want 1", prio_dbg); end
        checks++; if ({a_ready, b_ready} !== 2'b01) begin errors++; $display("FAIL cont_second_grant: got %b want 01", {a_ready, b_ready}); end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++; if (wr_sel !== 4'b0010) begin errors++; $display("FAIL cont_wr_sel_b: got %b want 0010", wr_sel); end
        checks++; if (wr_data !== 8'h22) begin errors++; $display("FAIL cont_wr_data_b: got %h want 22", wr_data); end
        checks++; if (prio_dbg !== 1'b0) begin errors++; $display("FAIL cont_prio_back: got %b want 0", prio_dbg); end
    endtask

    task automatic test_clear();
        apply_reset();
        @(negedge clk);
        clr_req = 1'b1;
        a_valid = 1'b1; a_addr = 2'd2; a_data = 8'h33;
        b_valid = 1'b1; b_addr = 2'd3; b_data = 8'h44;
        #1;
        checks++; if ({a_ready, b_ready} !== 2'b00) begin errors++; $display("FAIL clr_req_readys: got %b want 00", {a_ready, b_ready}); end
        checks++; if (clr_busy !== 1'b0) begin errors++; $display("FAIL clr_req_busy: got %b want 0", clr_busy); end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            clr_req = (k == 1);
            #1;
            checks++; if (clr_busy !== 1'b1) begin errors++; $display("FAIL clr_busy_%0d: got %b want 1", k, clr_busy); end
            checks++; if (wr_sel !== (4'b0001 << k)) begin errors++; $display("FAIL clr_wr_sel_%0d: got %b want %b", k, wr_sel, 4'b0001 << k); end
            checks++; if (wr_data !== 8'h00) begin errors++; $display("FAIL clr_wr_data_%0d: got %h want 00", k, wr_data); end
            checks++; if ({a_ready, b_ready} !== 2'b00) begin errors++; $display("FAIL clr_readys_%0d: got %b want 00", k, {a_ready, b_ready}); end
        end
        @(negedge clk);
        clr_req = 1'b0;
        #1;
        checks++; if (clr_busy !== 1'b0) begin errors++; $display("FAIL clr_done_busy: got %b want 0", clr_busy); end
        checks++; if (state_dbg !== ST_IDLE) begin errors++; $display("FAIL clr_done_state: got %0d want IDLE", state_dbg); end
        checks++; if (wr_sel !== 4'b0000) begin errors++; $display("FAIL clr_done_sel: got %b want 0000", wr_sel); end
        checks++; if ({a_ready, b_ready} !== 2'b10) begin errors++; $display("FAIL clr_held_grant: got %b want 10", {a_ready, b_ready}); end
        @(negedge clk);
        a_valid = 1'b0;
        #1;
        checks++; if (wr_sel !== 4'b0100 || wr_data !== 8'h33) begin errors++; $display("FAIL clr_held_a_write: got %b/%h want 0100/33", wr_sel, wr_data); end
        checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL clr_held_b_ready: got %b want 1", b_ready); end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++; if (wr_sel !== 4'b1000 || wr_data !== 8'h44) begin errors++; $display("FAIL clr_held_b_write: got %b/%h want 1000/44", wr_sel, wr_data); end
        checks++; if (prio_dbg !== 1'b1) begin errors++; $display("FAIL clr_held_prio: got %b want 1", prio_dbg); end
    endtask

    task automatic test_write_then_clear();
        apply_reset();
        @(negedge clk);
        a_valid = 1'b1; a_addr = 2'd1; a_data = 8'h77;
        #1;
        checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL wtc_a_ready: got %b want 1", a_ready); end
        @(negedge clk);
        a_valid = 1'b0; clr_req = 1'b1;
        #1;
        checks++; if (wr_sel !== 4'b0010 || wr_data !== 8'h77) begin errors++; $display("FAIL wtc_commit: got %b/%h want 0010/77", wr_sel, wr_data); end
        checks++; if (clr_busy !== 1'b0) begin errors++; $display("FAIL wtc_busy_early: got %b want 0", clr_busy); end
        @(negedge clk);
        clr_req = 1'b0;
        #1;
        checks++; if (tb_bank[1] !== 8'h77) begin errors++; $display("FAIL wtc_bank1_committed: got %h want 77", tb_bank[1]); end
        checks++; if (wr_sel !== 4'b0001 || clr_busy !== 1'b1) begin errors++; $display("FAIL wtc_clear_start: got %b busy %b want 0001 busy 1", wr_sel, clr_busy); end
        repeat (4) @(negedge clk);
        #1;
        checks++; if (clr_busy !== 1'b0) begin errors++; $display("FAIL wtc_done_busy: got %b want 0", clr_busy); end
        for (int i = 0; i < NREG; i++) begin
            checks++; if (tb_bank[i] !== 8'h00) begin errors++; $display("FAIL wtc_bank_%0d: got %h want 00", i, tb_bank[i]); end
        end
    endtask

    task automatic test_hazard();
        apply_reset();
        @(negedge clk);
        a_valid = 1'b1; a_addr = 2'd3; a_data = 8'h5C; rd_addr = 2'd3;
        #1;
        checks++; if (rd_hazard !== 1'b0) begin errors++; $display("FAIL haz_before: got %b want 0", rd_hazard); end
        checks++; if (rd_sel !== 2'd3) begin errors++; $display("FAIL haz_rd_sel3: got %0d want 3", rd_sel); end
        @(negedge clk);
        a_valid = 1'b0;
        #1;
        checks++; if (wr_sel !== 4'b1000) begin errors++; $display("FAIL haz_wr_sel: got %b want 1000", wr_sel); end
        checks++; if (rd_hazard !== 1'b1) begin errors++; $display("FAIL haz_hit: got %b want 1", rd_hazard); end
        rd_addr = 2'd1;
        #1;
        checks++; if (rd_hazard !== 1'b0) begin errors++; $display("FAIL haz_other_addr: got %b want 0", rd_hazard); end
        checks++; if (rd_sel !== 2'd1) begin errors++; $display("FAIL haz_rd_sel1: got %0d want 1", rd_sel); end
        @(negedge clk);
        rd_addr = 2'd3;
        #1;
        checks++; if (rd_hazard !== 1'b0) begin errors++; $display("FAIL haz_after: got %b want 0", rd_hazard); end
    endtask

    task automatic test_reset_in_clear();
        apply_reset();
        @(negedge clk);
        clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        #1;
        checks++; if (wr_sel !== 4'b0001) begin errors++; $display("FAIL ric_first: got %b want 0001", wr_sel); end
        @(negedge clk); #1;
        checks++; if (wr_sel !== 4'b0010) begin errors++; $display("FAIL ric_second: got %b want 0010", wr_sel); end
        reset = 1'b0;
        #1;
        checks++; if (wr_sel !== 4'b0000) begin errors++; $display("FAIL ric_async_sel: got %b want 0000", wr_sel); end
        checks++; if (clr_busy !== 1'b0) begin errors++; $display("FAIL ric_async_busy: got %b want 0", clr_busy); end
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk); #1;
            checks++; if (wr_sel !== 4'b0000 || clr_busy !== 1'b0) begin errors++; $display("FAIL ric_after_%0d: got %b busy %b want 0000 busy 0", k, wr_sel, clr_busy); end
        end
    endtask

    // Randomized run: the model keeps a schedule of bank writes (exp_q for
    // pending clear writes) and the arbitration rules, nothing more.
    task automatic test_random();
        logic            m_prio;
        logic [DW-1:0]   m_last;
        logic [DW-1:0]   m_bank [NREG];
        logic            cur_valid, cur_clear;
        logic [AW-1:0]   cur_addr;
        logic [DW-1:0]   cur_data;
        logic [AW+DW-1:0] exp_q[$];
        logic [AW+DW-1:0] ent;
        logic            a_hold, b_hold, ea, eb, exp_haz, quiet;
        logic [NREG-1:0] exp_sel;
        logic [DW-1:0]   exp_data;
        state_t          exp_st;

        apply_reset();
        m_prio = 1'b0; m_last = '0;
        for (int i = 0; i < NREG; i++) m_bank[i] = 8'hA5;
        cur_valid = 1'b0; cur_clear = 1'b0; cur_addr = '0; cur_data = '0;
        exp_q.delete();
        a_hold = 1'b0; b_hold = 1'b0;

        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            quiet = (n >= 388);
            if (!a_hold) begin
                a_valid = quiet ? 1'b0 : 1'($urandom_range(0, 1));
                a_addr  = AW'($urandom_range(0, NREG - 1));
                a_data  = DW'($urandom);
            end
            if (!b_hold) begin
                b_valid = quiet ? 1'b0 : 1'($urandom_range(0, 1));
                b_addr  = AW'($urandom_range(0, NREG - 1));
                b_data  = DW'($urandom);
            end
            clr_req = quiet ? 1'b0 : ($urandom_range(0, 15) == 0);
            rd_addr = AW'($urandom_range(0, NREG - 1));

            if (cur_clear || clr_req) begin
                ea = 1'b0; eb = 1'b0;
            end else begin
                ea = a_valid && (!b_valid || m_prio == 1'b0);
                eb = b_valid && (!a_valid || m_prio == 1'b1);
            end
            exp_sel = '0;
            if (cur_valid) exp_sel[cur_addr] = 1'b1;
            exp_data = cur_valid ? cur_data : m_last;
            exp_haz  = cur_valid && (cur_addr == rd_addr);
            exp_st   = cur_clear ? ST_CLEAR : ST_IDLE;
            #1;
            checks++; if (a_ready !== ea) begin errors++; $display("FAIL rnd_a_ready cyc %0d: got %b want %b", n, a_ready, ea); end
            checks++; if (b_ready !== eb) begin errors++; $display("FAIL rnd_b_ready cyc %0d: got %b want %b", n, b_ready, eb); end
            checks++; if (wr_sel !== exp_sel) begin errors++; $display("FAIL rnd_wr_sel cyc %0d: got %b want %b", n, wr_sel, exp_sel); end
            checks++; if (wr_data !== exp_data) begin errors++; $display("FAIL rnd_wr_data cyc %0d: got %h want %h", n, wr_data, exp_data); end
            checks++; if (rd_hazard !== exp_haz) begin errors++; $display("FAIL rnd_hazard cyc %0d: got %b want %b", n, rd_hazard, exp_haz); end
            checks++; if (clr_busy !== cur_clear) begin errors++; $display("FAIL rnd_clr_busy cyc %0d: got %b want %b", n, clr_busy, cur_clear); end
            checks++; if (state_dbg !== exp_st) begin errors++; $display("FAIL rnd_state cyc %0d: got %0d want %0d", n, state_dbg, exp_st); end
            checks++; if (prio_dbg !== m_prio) begin errors++; $display("FAIL rnd_prio cyc %0d: got %b want %b", n, prio_dbg, m_prio); end

            if (cur_valid) begin
                m_last = cur_data;
                m_bank[cur_addr] = cur_data;
            end
            if (!cur_clear && clr_req) begin
                for (int i = 0; i < NREG; i++) exp_q.push_back({AW'(i), {DW{1'b0}}});
            end
            if (exp_q.size() > 0) begin
                ent = exp_q.pop_front();
                cur_valid = 1'b1; cur_clear = 1'b1;
                cur_addr = ent[AW+DW-1:DW]; cur_data = ent[DW-1:0];
            end else if (ea) begin
                cur_valid = 1'b1; cur_clear = 1'b0; cur_addr = a_addr; cur_data = a_data;
                if (b_valid) m_prio = 1'b1;
            end else if (eb) begin
                cur_valid = 1'b1; cur_clear = 1'b0; cur_addr = b_addr; cur_data = b_data;
                if (a_valid) m_prio = 1'b0;
            end else begin
                cur_valid = 1'b0; cur_clear = 1'b0;
            end
            a_hold = a_valid && !ea;
            b_hold = b_valid && !eb;
        end

        @(negedge clk);
        idle_inputs();
        #1;
        checks++; if (a_hold || b_hold || cur_valid) begin errors++; $display("FAIL rnd_drain: hold %b%b pending %b want 000", a_hold, b_hold, cur_valid); end
        for (int i = 0; i < NREG; i++) begin
            checks++; if (tb_bank[i] !== m_bank[i]) begin errors++; $display("FAIL rnd_bank_%0d: got %h want %h", i, tb_bank[i], m_bank[i]); end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        reset = 1'b0;
        bank_preset = 1'b1;
        idle_inputs();
        test_reset();
        test_a_only();
        test_contention();
        test_clear();
        test_write_then_clear();
        test_hazard();
        test_reset_in_clear();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
